// File: rtl/id_ex_hazard_stage.sv
// ID/EX pipeline register with load-use hazard detection and a counted stall FSM.
// A hazard holds PC and IF/ID and inserts STALL_CYCLES bubbles into EX; flush kills the entering instruction.
module id_ex_hazard_stage #(
  parameter int CTRL_WIDTH   = 8,
  parameter int STALL_CYCLES = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [4:0]            id_rs_id,
  input  logic [4:0]            id_rt_id,
  input  logic                  id_uses_rt,
  input  logic [31:0]           id_rs_value,
  input  logic [31:0]           id_rt_value,
  input  logic [31:0]           id_imm,
  input  logic [4:0]            id_dest_id,
  input  logic [CTRL_WIDTH-1:0] id_ctrl,
  input  logic                  flush,
  output logic                  stall,
  output logic                  ex_valid,
  output logic [31:0]           ex_rs_value,
  output logic [31:0]           ex_rt_value,
  output logic [31:0]           ex_imm,
  output logic [4:0]            ex_rs_id,
  output logic [4:0]            ex_rt_id,
  output logic [4:0]            ex_dest_id,
  output logic [CTRL_WIDTH-1:0] ex_ctrl
);

  typedef enum logic {
    RUN,
    STALL
  } state_t;

  localparam logic [2:0] STALL_INIT = 3'(STALL_CYCLES - 1);
  localparam bit         MULTI      = (STALL_CYCLES > 1);

  state_t     state;
  logic [2:0] cnt;
  logic       hazard;
  logic       bubble;

  // A bubble in EX has ex_valid=0, so it can never be the source of a hazard.
  assign hazard = ex_valid && ex_ctrl[1] && (ex_dest_id != 5'd0) && id_valid &&
                  ((ex_dest_id == id_rs_id) || (id_uses_rt && (ex_dest_id == id_rt_id)));

  // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
  always_comb begin
    stall = 1'b0;
    if (!reset && !flush) begin
      stall = (state == STALL) || hazard;
    end
  end

  assign bubble = flush || stall;

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
  // all registers here are plain flops (no memory array), so each is reset explicitly.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= RUN;
      cnt         <= 3'd0;
      ex_valid    <= 1'b0;
      ex_rs_value <= '0;
      ex_rt_value <= '0;
      ex_imm      <= '0;
      ex_rs_id    <= '0;
      ex_rt_id    <= '0;
      ex_dest_id  <= '0;
      ex_ctrl     <= '0;
    end else begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_rs_value <= '0;
        ex_rt_value <= '0;
        ex_imm      <= '0;
        ex_rs_id    <= '0;
        ex_rt_id    <= '0;
        ex_dest_id  <= '0;
        ex_ctrl     <= '0;
      end else begin
        ex_valid    <= id_valid;
        ex_rs_value <= id_rs_value;
        ex_rt_value <= id_rt_value;
        ex_imm      <= id_imm;
        ex_rs_id    <= id_rs_id;
        ex_rt_id    <= id_rt_id;
        ex_dest_id  <= id_dest_id;
        ex_ctrl     <= id_ctrl;
      end

      unique case (state)
        RUN: begin
          // With a single bubble the EX bubble itself clears the hazard, so RUN suffices.
          if (!flush && hazard && MULTI) begin
            state <= STALL;
            cnt   <= STALL_INIT;
          end
        end
        STALL: begin
          if (flush) begin
            state <= RUN;
            cnt   <= 3'd0;
          end else begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1) state <= RUN;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 3'd0;
        end
      endcase
    end
  end

endmodule
